pr_region_scheduler: RTL and testbench

//   Sequences the three partial-reconfiguration pixel regions and arbitrates the single shared

---
 rtl/pr_region_scheduler.sv | 227 ++++++++++++++++++++++
 tb/tb_pr_region_scheduler.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pr_region_scheduler.sv
// rtl/pr_region_scheduler.sv - PR region sequencer, ICAP arbiter, BRAM window addressing and VGA colour mux
module pr_region_scheduler #(
    parameter int          V_ACTIVE       = 480,
    parameter int          IMG_W          = 160,
    parameter int          IMG_H          = 115,
    parameter int          R0_X0          = 100,
    parameter int          R0_Y0          = 100,
    parameter int          R1_X0          = 300,
    parameter int          R1_Y0          = 100,
    parameter int          R2_X0          = 100,
    parameter int          R2_Y0          = 260,
    parameter int          ADDR_W         = 15,
    parameter int          PIPE_DLY       = 3,
    parameter int          SETTLE_FRAMES  = 1,
    parameter int          TIMEOUT_FRAMES = 4,
    parameter logic [11:0] DECOUPLE_RGB   = 12'h000
) (
    input  logic              pixel_clk,
    input  logic              reset,
    input  logic              blank,
    input  logic [9:0]        hc,
    input  logic [9:0]        vc,
    input  logic [11:0]       rgb0,
    input  logic [11:0]       rgb1,
    input  logic [11:0]       rgb2,
    input  logic [2:0]        pr_req,
    input  logic              pr_done,
    output logic [2:0]        pr_grant,
    output logic [2:0]        decouple,
    output logic              pr_busy,
    output logic              pr_err,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [3:0]        redx,
    output logic [3:0]        greenx,
    output logic [3:0]        bluex
);

    localparam logic [9:0] WIN_W = 10'(IMG_W);
    localparam logic [9:0] WIN_H = 10'(IMG_H);
    localparam logic [9:0] X0_0  = 10'(R0_X0);
    localparam logic [9:0] Y0_0  = 10'(R0_Y0);
    localparam logic [9:0] X0_1  = 10'(R1_X0);
    localparam logic [9:0] Y0_1  = 10'(R1_Y0);
    localparam logic [9:0] X0_2  = 10'(R2_X0);
    localparam logic [9:0] Y0_2  = 10'(R2_Y0);
    localparam int FMAX   = (TIMEOUT_FRAMES > SETTLE_FRAMES) ? TIMEOUT_FRAMES : SETTLE_FRAMES;
    localparam int FCNT_W = $clog2(FMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_FRAME,
        S_DECOUPLE,
        S_WAIT_DONE,
        S_SETTLE
    } state_t;

    function automatic logic in_win(input logic [9:0] x, input logic [9:0] y,
                                    input logic [9:0] x0, input logic [9:0] y0);
        return (x >= x0) && (x < x0 + WIN_W) && (y >= y0) && (y < y0 + WIN_H);
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] k);
        return 3'b001 << k;
    endfunction

    // First requesting region at or after the pointer, wrapping 2 -> 0.
    function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
        logic [2:0] s;
        logic [1:0] pick;
        pick = ptr;
        for (int i = 2; i >= 0; i--) begin
            s = {1'b0, ptr} + 3'(i);
            if (s >= 3'd3) s = s - 3'd3;
            if (req[s[1:0]]) pick = s[1:0];
        end
        return pick;
    endfunction

    logic       hit;
    logic [1:0] hit_id;
    logic [9:0] dx;
    logic [9:0] dy;
    logic       frame_edge;

    assign frame_edge = (hc == 10'd0) && (vc == 10'(V_ACTIVE));

    always_comb begin
        hit    = 1'b0;
        hit_id = 2'd0;
        dx     = 10'd0;
        dy     = 10'd0;
        if (!blank) begin
            if (in_win(hc, vc, X0_0, Y0_0)) begin
                hit = 1'b1; hit_id = 2'd0; dx = hc - X0_0; dy = vc - Y0_0;
            end else if (in_win(hc, vc, X0_1, Y0_1)) begin
                hit = 1'b1; hit_id = 2'd1; dx = hc - X0_1; dy = vc - Y0_1;
            end else if (in_win(hc, vc, X0_2, Y0_2)) begin
                hit = 1'b1; hit_id = 2'd2; dx = hc - X0_2; dy = vc - Y0_2;
            end
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
        end else begin
            rd_en   <= hit;
            rd_addr <= hit ? ADDR_W'(dy) * ADDR_W'(IMG_W) + ADDR_W'(dx) : '0;
        end
    end

    // Hit tag travels alongside the BRAM/region pipeline so the mux lines up with rgbk.
    logic [PIPE_DLY-1:0] dly_v;
    logic [1:0]          dly_id [PIPE_DLY];
    logic [11:0]         pix;

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            dly_v <= '0;
            for (int i = 0; i < PIPE_DLY; i++) dly_id[i] <= 2'd0;
        end else begin
            dly_v[0]  <= hit;
            dly_id[0] <= hit_id;
            for (int i = 1; i < PIPE_DLY; i++) begin
                dly_v[i]  <= dly_v[i-1];
                dly_id[i] <= dly_id[i-1];
            end
        end
    end

    always_comb begin
        pix = 12'h000;
        if (dly_v[PIPE_DLY-1]) begin
            case (dly_id[PIPE_DLY-1])
                2'd0:    pix = decouple[0] ? DECOUPLE_RGB : rgb0;
                2'd1:    pix = decouple[1] ? DECOUPLE_RGB : rgb1;
                2'd2:    pix = decouple[2] ? DECOUPLE_RGB : rgb2;
                default: pix = 12'h000;
            endcase
        end
    end

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            {redx, greenx, bluex} <= 12'h000;
        end else begin
            {redx, greenx, bluex} <= pix;
        end
    end

    state_t            state;
    logic [1:0]        sel;
    logic [1:0]        rr;
    logic [1:0]        pick;
    logic [FCNT_W-1:0] fcnt;

    assign pick = rr_pick(pr_req, rr);

    always_ff @(posedge pixel_clk or posedge reset) begin
        if (reset) begin
            state    <= S_IDLE;
            sel      <= 2'd0;
            rr       <= 2'd0;
            fcnt     <= '0;
            pr_grant <= 3'b000;
            decouple <= 3'b000;
            pr_busy  <= 1'b0;
            pr_err   <= 1'b0;
        end else begin
            pr_err <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (|pr_req) begin
                        sel     <= pick;
                        rr      <= (pick == 2'd2) ? 2'd0 : pick + 2'd1;
                        pr_busy <= 1'b1;
                        state   <= S_WAIT_FRAME;
                    end
                end
                S_WAIT_FRAME: begin
                    if (frame_edge) begin
                        decouple <= onehot(sel);
                        state    <= S_DECOUPLE;
                    end
                end
                S_DECOUPLE: begin
                    pr_grant <= onehot(sel);
                    fcnt     <= '0;
                    state    <= S_WAIT_DONE;
                end
                S_WAIT_DONE: begin
                    // pr_done takes priority over a timeout on the same cycle.
                    if (pr_done) begin
                        pr_grant <= 3'b000;
                        fcnt     <= '0;
                        state    <= S_SETTLE;
                    end else if (frame_edge) begin
                        if (fcnt == FCNT_W'(TIMEOUT_FRAMES - 1)) begin
                            pr_grant <= 3'b000;
                            pr_err   <= 1'b1;
                            fcnt     <= '0;
                            state    <= S_SETTLE;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                S_SETTLE: begin
                    if (frame_edge) begin
                        if (fcnt == FCNT_W'(SETTLE_FRAMES - 1)) begin
                            decouple <= 3'b000;
                            pr_busy  <= 1'b0;
                            fcnt     <= '0;
                            state    <= S_IDLE;
                        end else begin
                            fcnt <= fcnt + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pr_region_scheduler.sv
// tb/tb_pr_region_scheduler.sv - directed bench with a behavioural scheduler/raster model for pr_region_scheduler
module tb_pr_region_scheduler;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        blank = 1'b1;
    logic [9:0]  hc = 10'd700;
    logic [9:0]  vc = 10'd10;
    logic [11:0] rgb0 = 12'h123;
    logic [11:0] rgb1 = 12'hABC;
    logic [11:0] rgb2 = 12'h456;
    logic [2:0]  pr_req = 3'b000;
    logic        pr_done = 1'b0;

    logic [2:0]  pr_grant;
    logic [2:0]  decouple;
    logic        pr_busy;
    logic        pr_err;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [3:0]  redx;
    logic [3:0]  greenx;
    logic [3:0]  bluex;

    int checks = 0;
    int errors = 0;

    pr_region_scheduler dut (
        .pixel_clk(clk),
        .reset(reset),
        .blank(blank),
        .hc(hc),
        .vc(vc),
        .rgb0(rgb0),
        .rgb1(rgb1),
        .rgb2(rgb2),
        .pr_req(pr_req),
        .pr_done(pr_done),
        .pr_grant(pr_grant),
        .decouple(decouple),
        .pr_busy(pr_busy),
        .pr_err(pr_err),
        .rd_en(rd_en),
        .rd_addr(rd_addr),
        .redx(redx),
        .greenx(greenx),
        .bluex(bluex)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: windows as plain rectangles, output a fixed number of edges later.
    int          wx [3] = '{100, 300, 100};
    int          wy [3] = '{100, 100, 260};
    int          m_phase = 0;
    int          m_sel = 0;
    int          m_rr = 0;
    int          m_frames = 0;
    int          m_r;
    int          m_k;
    int          m_pipe [$];
    logic [2:0]  m_grant = 3'b000;
    logic [2:0]  m_dec = 3'b000;
    logic        m_busy = 1'b0;
    logic        m_err = 1'b0;
    logic        m_rd_en = 1'b0;
    logic [14:0] m_addr = 15'd0;
    logic [11:0] m_rgb = 12'h000;
    logic        m_edge;

    function automatic int region_at(input logic b, input int x, input int y);
        if (b) return -1;
        for (int k = 0; k < 3; k++)
            if (x >= wx[k] && x < wx[k] + 160 && y >= wy[k] && y < wy[k] + 115) return k;
        return -1;
    endfunction

    initial forever begin
        @(posedge clk or posedge reset);
        if (reset) begin
            m_phase = 0; m_sel = 0; m_rr = 0; m_frames = 0;
            m_grant = 3'b000; m_dec = 3'b000; m_busy = 1'b0; m_err = 1'b0;
            m_rd_en = 1'b0; m_addr = 15'd0; m_rgb = 12'h000;
            m_pipe.delete();
        end else begin
            m_edge = (hc == 10'd0) && (vc == 10'd480);
            m_r = region_at(blank, int'(hc), int'(vc));
            m_rd_en = (m_r >= 0);
            m_addr = (m_r >= 0) ? 15'((int'(vc) - wy[m_r]) * 160 + int'(hc) - wx[m_r]) : 15'd0;
            m_pipe.push_back(m_r);
            m_rgb = 12'h000;
            if (m_pipe.size() > 3) begin
                m_k = m_pipe.pop_front();
                if (m_k >= 0)
                    m_rgb = m_dec[m_k] ? 12'h000 : (m_k == 0 ? rgb0 : (m_k == 1 ? rgb1 : rgb2));
            end
            m_err = 1'b0;
            case (m_phase)
                0: if (pr_req != 3'b000) begin
                    for (int off = 2; off >= 0; off--)
                        if (pr_req[(m_rr + off) % 3]) m_sel = (m_rr + off) % 3;
                    m_rr = (m_sel + 1) % 3;
                    m_busy = 1'b1;
                    m_phase = 1;
                end
                1: if (m_edge) begin
                    m_dec = 3'b000;
                    m_dec[m_sel] = 1'b1;
                    m_phase = 2;
                end
                2: begin
                    m_grant = 3'b000;
                    m_grant[m_sel] = 1'b1;
                    m_frames = 0;
                    m_phase = 3;
                end
                3: if (pr_done) begin
                    m_grant = 3'b000; m_frames = 0; m_phase = 4;
                end else if (m_edge) begin
                    m_frames++;
                    if (m_frames == 4) begin
                        m_grant = 3'b000; m_err = 1'b1; m_frames = 0; m_phase = 4;
                    end
                end
                default: if (m_edge) begin
                    m_frames++;
                    if (m_frames == 1) begin
                        m_dec = 3'b000; m_busy = 1'b0; m_frames = 0; m_phase = 0;
                    end
                end
            endcase
        end
    end

    initial forever begin
        @(negedge clk);
        chk("rd_en", rd_en, m_rd_en);
        chk("rd_addr", rd_addr, m_addr);
        chk("rgb", {redx, greenx, bluex}, m_rgb);
        chk("pr_grant", pr_grant, m_grant);
        chk("decouple", decouple, m_dec);
        chk("pr_busy", pr_busy, m_busy);
        chk("pr_err", pr_err, m_err);
        chk("grant_onehot", 32'($countones(pr_grant) <= 1), 32'd1);
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic idle();
        blank = 1'b1; hc = 10'd700; vc = 10'd10;
    endtask

    task automatic frame_edge();
        blank = 1'b1; hc = 10'd0; vc = 10'd480;
        step();
        idle();
    endtask

    task automatic pixel(input int x, input int y);
        blank = 1'b0; hc = 10'(x); vc = 10'(y);
        step();
        idle();
    endtask

    initial begin
        step(3);
        reset = 1'b0;
        chk("rst_grant", pr_grant, 3'b000);
        chk("rst_busy", pr_busy, 1'b0);
        chk("rst_rgb", {redx, greenx, bluex}, 12'h000);

        // addressing
        blank = 1'b0; hc = 10'd100; vc = 10'd100;
        step();
        chk("addr_origin", rd_addr, 15'd0);
        chk("addr_origin_en", rd_en, 1'b1);
        hc = 10'd259; vc = 10'd214;
        step();
        chk("addr_corner", rd_addr, 15'd18399);
        idle();
        step(4);

        // colour mux latency
        pixel(300, 100);
        step(2);
        chk("rgb_early", {redx, greenx, bluex}, 12'h000);
        step();
        chk("rgb_win1", {redx, greenx, bluex}, 12'hABC);
        step();
        chk("rgb_after", {redx, greenx, bluex}, 12'h000);
        blank = 1'b1; hc = 10'd300; vc = 10'd100;
        step();
        chk("blank_en", rd_en, 1'b0);
        idle();
        step(3);
        chk("blank_rgb", {redx, greenx, bluex}, 12'h000);

        // round robin 0 then 2
        pr_req = 3'b101;
        step();
        chk("busy_sel", pr_busy, 1'b1);
        step(5);
        blank = 1'b1; hc = 10'd1; vc = 10'd480;
        step();
        hc = 10'd0; vc = 10'd479;
        step();
        idle();
        chk("dec_not_yet", decouple, 3'b000);
        frame_edge();
        chk("dec_r0", decouple, 3'b001);
        chk("grant_pre", pr_grant, 3'b000);
        step();
        chk("grant_r0", pr_grant, 3'b001);
        pr_req = 3'b100;
        step(3);
        pr_done = 1'b1; step(); pr_done = 1'b0;
        chk("grant_r0_drop", pr_grant, 3'b000);
        frame_edge();
        chk("dec_r0_clr", decouple, 3'b000);
        step();
        frame_edge();
        chk("dec_r2", decouple, 3'b100);
        step();
        chk("grant_r2", pr_grant, 3'b100);
        pr_req = 3'b000;
        pr_done = 1'b1; step(); pr_done = 1'b0;
        frame_edge();

        // done then settle, window blanked to decouple colour
        pr_req = 3'b010;
        step();
        frame_edge();
        step();
        chk("grant_r1", pr_grant, 3'b010);
        pr_req = 3'b000;
        pixel(300, 100);
        step(3);
        chk("win1_decoupled", {redx, greenx, bluex}, 12'h000);
        pr_done = 1'b1; step(); pr_done = 1'b0;
        chk("grant_r1_drop", pr_grant, 3'b000);
        chk("dec_r1_hold", decouple, 3'b010);
        pixel(300, 100);
        step(3);
        chk("win1_settle", {redx, greenx, bluex}, 12'h000);
        frame_edge();
        chk("dec_r1_clr", decouple, 3'b000);
        pixel(300, 100);
        step(3);
        chk("win1_restored", {redx, greenx, bluex}, 12'hABC);

        // timeout
        pr_req = 3'b001;
        step();
        frame_edge();
        step();
        chk("grant_to", pr_grant, 3'b001);
        pr_req = 3'b000;
        for (int i = 0; i < 3; i++) begin
            frame_edge();
            step(2);
        end
        chk("to_hold_grant", pr_grant, 3'b001);
        chk("to_no_err", pr_err, 1'b0);
        frame_edge();
        chk("to_err", pr_err, 1'b1);
        chk("to_grant_drop", pr_grant, 3'b000);
        step();
        chk("to_err_pulse", pr_err, 1'b0);
        chk("to_busy", pr_busy, 1'b1);
        frame_edge();
        chk("to_idle", pr_busy, 1'b0);
        chk("to_dec_clr", decouple, 3'b000);

        // reset in WAIT_DONE clears pointer too
        pr_req = 3'b001;
        step();
        frame_edge();
        step();
        chk("grant_pre_rst", pr_grant, 3'b001);
        step(2);
        reset = 1'b1;
        #1;
        chk("rst_mid_grant", pr_grant, 3'b000);
        chk("rst_mid_dec", decouple, 3'b000);
        chk("rst_mid_busy", pr_busy, 1'b0);
        step(2);
        reset = 1'b0;
        pr_req = 3'b011;
        step();
        frame_edge();
        step();
        chk("rr_after_rst", pr_grant, 3'b001);
        pr_req = 3'b000;
        pr_done = 1'b1; step(); pr_done = 1'b0;
        frame_edge();
        step(2);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
